// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared register, with bounded
// multi-cycle ownership (lock) so a single writer cannot starve the others.
module shared_reg_arbiter #(
  parameter int                NREQ     = 4,
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  INIT     = '0,
  parameter int                MAX_LOCK = 8,
  localparam int               OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int               CW       = $clog2(MAX_LOCK + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      out,
  output logic                  locked,
  output logic [OW-1:0]         owner
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Power-up contents mimic the team register primitive (1010... from the MSB).
  function automatic logic [WIDTH-1:0] alt_pattern();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[i] = ((WIDTH - 1 - i) % 2) == 0;
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] next_index(input logic [OW-1:0] i);
    return (i == OW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q = alt_pattern();

  logic             scan_hit;
  logic [OW-1:0]    scan_win;
  logic             win_valid;
  logic [OW-1:0]    win;
  logic [NREQ-1:0]  grant_c;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    int s;
    scan_hit = 1'b0;
    scan_win = '0;
    s        = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= NREQ) begin
        s = s - NREQ;
      end
      if (!scan_hit && req[OW'(s)]) begin
        scan_hit = 1'b1;
        scan_win = OW'(s);
      end
    end
  end

  // Grant selection and next-state logic for the ownership FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    win_valid = 1'b0;
    win       = owner_q;

    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            win_valid = 1'b1;
            win       = scan_win;
            ptr_d     = next_index(scan_win);
            owner_d   = scan_win;
            if (lock[scan_win] && (MAX_LOCK > 1)) begin
              state_d = LOCKED;
              cnt_d   = CW'(1);
            end
          end
        end
        LOCKED: begin
          if (req[owner_q]) begin
            win_valid = 1'b1;
            win       = owner_q;
            if (lock[owner_q] && ((cnt_q + 1'b1) != CW'(MAX_LOCK))) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              ptr_d   = next_index(owner_q);
            end
          end else begin
            // Owner walked away: give up the lock without writing this cycle.
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = next_index(owner_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    grant_c = win_valid ? (NREQ'(1) << win) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= INIT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (win_valid) begin
        data_q <= wdata[int'(win)*WIDTH +: WIDTH];
      end
    end
  end

  assign grant  = grant_c;
  assign out    = data_q;
  assign locked = (state_q == LOCKED);
  assign owner  = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random
// traffic compared against a rule-level model of the arbiter.
module tb_shared_reg_arbiter;

  localparam int          N    = 4;
  localparam int          W    = 8;
  localparam logic [7:0]  INIT = 8'h5A;
  localparam int          ML   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    lock = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    grant;
  logic [7:0]    out;
  logic          locked;
  logic [1:0]    owner;

  shared_reg_arbiter #(
    .NREQ(N), .WIDTH(W), .INIT(INIT), .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
    .grant(grant), .out(out), .locked(locked), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int         m_ptr = 0;
  int         m_owner = 0;
  int         m_held = 0;
  bit         m_locked = 1'b0;
  bit         m_known = 1'b0;
  logic [7:0] m_out = '0;

  logic [3:0] last_grant;
  logic [7:0] last_out;
  logic       last_locked;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit bitOf(input logic [3:0] v, input int idx);
    return ((v >> idx) & 4'd1) != 4'd0;
  endfunction

  // Which requester the rules say wins this cycle; -1 means no grant.
  function automatic int modelWinner();
    if (!rst_n) return -1;
    if (m_locked) return bitOf(req, m_owner) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (bitOf(req, (m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task applyStimulus(input logic rn, input logic [3:0] r, input logic [3:0] l,
                     input logic [31:0] wd);
    int         w;
    logic [3:0] exp_g;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    lock  = l;
    wdata = wd;
    #1;
    w     = modelWinner();
    exp_g = (w < 0) ? 4'd0 : 4'(1 << w);
    last_grant  = grant;
    last_out    = out;
    last_locked = locked;
    checkOutput("grant", grant, exp_g);
    if (m_known) begin
      checkOutput("out", out, m_out);
      checkOutput("locked", locked, m_locked);
      checkOutput("owner", owner, m_owner);
    end
    @(posedge clk);
    if (!rn) begin
      m_known  = 1'b1;
      m_out    = INIT;
      m_ptr    = 0;
      m_owner  = 0;
      m_locked = 1'b0;
      m_held   = 0;
    end else if (!m_locked) begin
      if (w >= 0) begin
        m_out   = 8'(wd >> (w * W));
        m_owner = w;
        m_ptr   = (w + 1) % N;
        if (bitOf(l, w) && ML > 1) begin
          m_locked = 1'b1;
          m_held   = 1;
        end
      end
    end else if (w >= 0) begin
      m_out  = 8'(wd >> (w * W));
      m_held = m_held + 1;
      if (!bitOf(l, m_owner) || m_held == ML) begin
        m_locked = 1'b0;
        m_held   = 0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else begin
      m_locked = 1'b0;
      m_held   = 0;
      m_ptr    = (m_owner + 1) % N;
    end
  endtask

  localparam logic [31:0] RR_DATA = 32'h13121110;

  initial begin
    logic [3:0] rr_exp [5];
    logic [3:0] r, l;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with every requester asking.
    applyStimulus(1'b0, 4'b1111, 4'b0000, RR_DATA);
    checkOutput("rst_grant0", last_grant, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000, RR_DATA);
    checkOutput("rst_grant1", last_grant, 4'b0000);
    checkOutput("rst_out", last_out, INIT);
    checkOutput("rst_locked", last_locked, 1'b0);

    // Plain round robin.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b0000, RR_DATA);
      checkOutput("rr_grant", last_grant, rr_exp[i]);
      if (i > 0) checkOutput("rr_out", last_out, 32'h10 + i - 1);
    end

    // Move ptr to 3, then check the wrap from 3 to 0 and the skip to 2.
    applyStimulus(1'b1, 4'b0100, 4'b0000, 32'hA3A2A1A0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 32'hA3A2A1A0);
    checkOutput("wrap_grant", last_grant, 4'b0001);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 32'hA3A2A1A0);
    checkOutput("skip_grant", last_grant, 4'b0100);

    // Lock held two cycles, then released with a final write.
    applyStimulus(1'b1, 4'b0101, 4'b0001, 32'hB3B2B1B0);
    checkOutput("lk_grant0", last_grant, 4'b0001);
    checkOutput("lk_locked0", last_locked, 1'b0);
    applyStimulus(1'b1, 4'b0101, 4'b0001, 32'hB3B2B1C0);
    checkOutput("lk_grant1", last_grant, 4'b0001);
    checkOutput("lk_locked1", last_locked, 1'b1);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 32'hB3B2B1D0);
    checkOutput("lk_grant2", last_grant, 4'b0001);
    checkOutput("lk_locked2", last_locked, 1'b1);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 32'hB3B2B1B0);
    checkOutput("lk_grant3", last_grant, 4'b0100);
    checkOutput("lk_locked3", last_locked, 1'b0);
    checkOutput("lk_out", last_out, 8'hD0);

    // Starvation limit: requester 1 keeps asking for the lock.
    applyStimulus(1'b1, 4'b0001, 4'b0000, 32'hC3C2C1C0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b1010, 4'b0010, 32'hC3C2C1C0);
      checkOutput("starve_grant", last_grant, 4'b0010);
      checkOutput("starve_locked", last_locked, i > 0);
    end
    applyStimulus(1'b1, 4'b1010, 4'b0010, 32'hC3C2C1C0);
    checkOutput("starve_release", last_grant, 4'b1000);
    checkOutput("starve_unlocked", last_locked, 1'b0);

    // Reset in the middle of a lock.
    applyStimulus(1'b1, 4'b0010, 4'b0010, 32'hD3D2D1D0);
    applyStimulus(1'b1, 4'b0010, 4'b0010, 32'hD3D2D1D0);
    checkOutput("midrst_pre", last_locked, 1'b1);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 32'hD3D2D1D0);
    applyStimulus(1'b1, 4'b1010, 4'b0000, 32'hD3D2D1D0);
    checkOutput("midrst_grant", last_grant, 4'b0010);
    checkOutput("midrst_out", last_out, INIT);
    checkOutput("midrst_locked", last_locked, 1'b0);

    // Random traffic, biased so lock owners often keep asking.
    for (int i = 0; i < 600; i++) begin
      r = 4'($urandom);
      l = 4'($urandom);
      if (m_locked && $urandom_range(0, 3) != 0) begin
        r = r | 4'(1 << m_owner);
        if ($urandom_range(0, 3) != 0) l = l | 4'(1 << m_owner);
      end
      applyStimulus($urandom_range(0, 49) != 0, r, l, $urandom);
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
